bbc_keyboard: RTL and testbench
===============================

BBC_KEYBOARD -- requirements
Module: bbc_keyboard

Interface
REQ-001 SHALL have parameter DIP_LINKS, default 8'h00, giving the startup link states for row 0, columns 2-9; bit n maps to column n+2, and 1 reads as pressed.
REQ-002 SHALL have parameter TIMEOUT, default 16'd20000, giving the number of clk cycles without a PS/2 falling edge after which a partial frame is abandoned.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports, in order:
- clk  in  1  system clock.
- RESET  in  1  synchronous active-high reset.
- clk_en  in  1  1 MHz enable; same strobe as the system VIA clk_en.
- PS2_CLK  in  1  raw PS/2 clock, asynchronous.
- PS2_DATA  in  1  raw PS/2 data, asynchronous.
- nKBEN  in  1  latch bit 3; 0 = manual scan, 1 = autoscan.
- KB_ADDR  in  7  VIA PA[6:0]; [3:0] = column, [6:4] = row.
- KB_PA7  out  1  key at KB_ADDR pressed; drives VIA PA7.
- KB_CA2  out  1  any key in rows 1-7 of the scanned column pressed; drives VIA CA2.
- BREAK  out  1  Break key held.

Function
REQ-005 SHALL pass PS2_CLK and PS2_DATA through 2-flop synchronisers and SHALL act on the synchronised PS2_CLK falling edge only; this path is independent of clk_en.
REQ-006 Receiver SHALL be a frame state machine: IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
- IDLE leaves only on a falling edge with data = 0.
- A frame is valid only if parity is odd and the stop bit is 1.
REQ-007 An invalid frame SHALL be discarded, and the E0 and F0 flags SHALL be cleared.
REQ-008 If TIMEOUT cycles pass with no falling edge while outside IDLE, the receiver SHALL return to IDLE and discard the partial byte.
REQ-009 Byte decode:
- 0xE0 sets the ext flag.
- 0xF0 sets the brk flag.
- Any other byte is looked up as {ext, byte}, then both flags clear.
REQ-010 The lookup SHALL return valid, row[2:0] and col[3:0].
- If valid, matrix bit [row][col] SHALL be set on make (brk = 0) and cleared on break (brk = 1).
- If invalid, the byte SHALL be ignored.
REQ-011 Byte 0x07 (F12) SHALL drive BREAK: 1 on make, 0 on break. It SHALL NOT enter the matrix.
REQ-012 The matrix SHALL be 8 rows x 10 columns; addresses with column 10-15 SHALL read as not pressed.
REQ-013 Row 0, columns 2-9 SHALL read as DIP_LINKS, not the PS/2 matrix.
REQ-014 KB_PA7 SHALL be combinational from KB_ADDR and the matrix (zero-cycle latency), because the VIA samples it in the same cycle.
REQ-015 A matrix update SHALL become visible on KB_PA7 and KB_CA2 on the clk edge after the STOP bit is accepted.
REQ-016 Column counter (4-bit):
- nKBEN = 1: increments on each clk_en and wraps 15 -> 0.
- nKBEN = 0: holds its value.
REQ-017 The scanned column SHALL be the counter when nKBEN = 1, and KB_ADDR[3:0] when nKBEN = 0.
REQ-018 KB_CA2 SHALL be registered: on each clk_en it SHALL load the OR of rows 1-7 of the scanned column. Row 0 SHALL be excluded, so Shift, Ctrl and the links never raise CA2.
REQ-019 If nKBEN toggles in the same cycle as clk_en, the counter SHALL obey the new nKBEN value.

Reset
REQ-020 RESET SHALL apply the following, with precedence over every other event, including a frame in progress:
- receiver -> IDLE, bit count 0, ext and brk flags 0;
- matrix all 0;
- BREAK 0;
- column counter 0;
- KB_CA2 0.
REQ-021 After reset, KB_PA7 SHALL equal the link bit for a row-0 link address and 0 for every other address.

Structure
REQ-022 The codebase's shared header SHALL hold the PS/2 constants (0xE0, 0xF0, 0x07) and the receiver state encodings.
REQ-023 The scancode-to-matrix lookup SHALL be a combinational sub-module named ps2_to_bbc: input {ext, byte} (9 bits), outputs valid, row and col.

Verification
REQ-024 Send PS/2 0x1C; set KB_ADDR = 0x41, nKBEN = 0 -> KB_PA7 = 1 after the stop bit; send F0 1C -> KB_PA7 = 0.
REQ-025 Hold 0x29 (Space, row 6 col 2) with nKBEN = 1 -> KB_CA2 = 1 exactly when the counter reaches 2, once per 16 clk_en; 0 otherwise.
REQ-026 Hold 0x12 (Shift, row 0 col 0) in autoscan -> KB_CA2 never 1; KB_ADDR = 0x00 manual -> KB_PA7 = 1.
REQ-027 Send 0x1C with a bad parity bit -> matrix unchanged; stop after 5 data bits, wait TIMEOUT cycles, send 0x76 -> KB_ADDR = 0x70 reads 1.
REQ-028 Send 0x07 -> BREAK = 1; assert RESET mid-frame while 0x1C is held -> matrix 0, BREAK 0, KB_CA2 0, counter 0.
REQ-029 With DIP_LINKS = 8'hA5 -> KB_ADDR 0x02..0x09 read 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/bbc_keyboard_pkg.sv
// BBC Micro keyboard shared definitions.
// PS/2 prefix codes, special keys and receiver states.
package bbc_keyboard_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_F12 = 8'h07;

    localparam int N_ROWS = 8;
    localparam int N_COLS = 10;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/ps2_to_bbc.sv
// PS/2 set-2 scancode to BBC matrix position.
// Position is packed as {row[2:0], col[3:0]} = matrix address.
module ps2_to_bbc (
    input  logic [8:0] code,
    output logic       valid,
    output logic [2:0] row,
    output logic [3:0] col
);

    logic [6:0] rc;

    // Lookup of {ext, byte}; unknown codes report invalid
    always_comb begin
        valid = 1'b1;
        rc    = 7'h00;
        case (code)
            9'h012: rc = 7'h00;
            9'h059: rc = 7'h00;
            9'h014: rc = 7'h01;
            9'h015: rc = 7'h10;
            9'h026: rc = 7'h11;
            9'h025: rc = 7'h12;
            9'h02E: rc = 7'h13;
            9'h00C: rc = 7'h14;
            9'h03E: rc = 7'h15;
            9'h083: rc = 7'h16;
            9'h04E: rc = 7'h17;
            9'h055: rc = 7'h18;
            9'h16B: rc = 7'h19;
            9'h009: rc = 7'h20;
            9'h01D: rc = 7'h21;
            9'h024: rc = 7'h22;
            9'h02C: rc = 7'h23;
            9'h03D: rc = 7'h24;
            9'h043: rc = 7'h25;
            9'h046: rc = 7'h26;
            9'h045: rc = 7'h27;
            9'h00E: rc = 7'h28;
            9'h172: rc = 7'h29;
            9'h016: rc = 7'h30;
            9'h01E: rc = 7'h31;
            9'h023: rc = 7'h32;
            9'h02D: rc = 7'h33;
            9'h036: rc = 7'h34;
            9'h03C: rc = 7'h35;
            9'h044: rc = 7'h36;
            9'h04D: rc = 7'h37;
            9'h054: rc = 7'h38;
            9'h175: rc = 7'h39;
            9'h058: rc = 7'h40;
            9'h01C: rc = 7'h41;
            9'h022: rc = 7'h42;
            9'h02B: rc = 7'h43;
            9'h035: rc = 7'h44;
            9'h03B: rc = 7'h45;
            9'h042: rc = 7'h46;
            9'h052: rc = 7'h48;
            9'h05A: rc = 7'h49;
            9'h011: rc = 7'h50;
            9'h01B: rc = 7'h51;
            9'h021: rc = 7'h52;
            9'h034: rc = 7'h53;
            9'h033: rc = 7'h54;
            9'h031: rc = 7'h55;
            9'h04B: rc = 7'h56;
            9'h04C: rc = 7'h57;
            9'h05B: rc = 7'h58;
            9'h066: rc = 7'h59;
            9'h00D: rc = 7'h60;
            9'h01A: rc = 7'h61;
            9'h029: rc = 7'h62;
            9'h02A: rc = 7'h63;
            9'h032: rc = 7'h64;
            9'h03A: rc = 7'h65;
            9'h041: rc = 7'h66;
            9'h049: rc = 7'h67;
            9'h04A: rc = 7'h68;
            9'h169: rc = 7'h69;
            9'h076: rc = 7'h70;
            9'h005: rc = 7'h71;
            9'h006: rc = 7'h72;
            9'h004: rc = 7'h73;
            9'h003: rc = 7'h74;
            9'h00B: rc = 7'h75;
            9'h00A: rc = 7'h76;
            9'h001: rc = 7'h77;
            9'h05D: rc = 7'h78;
            9'h174: rc = 7'h79;
            default: valid = 1'b0;
        endcase
    end

    assign row = rc[6:4];
    assign col = rc[3:0];

endmodule

// File: rtl/bbc_keyboard.sv
// BBC Micro keyboard matrix emulated from a PS/2 keyboard.
// PS/2 receiver, key matrix, column scanner and CA2 interrupt.
import bbc_keyboard_pkg::*;

module bbc_keyboard #(
    parameter logic [7:0]  DIP_LINKS = 8'h00,
    parameter logic [15:0] TIMEOUT   = 16'd20000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       clk_en,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       nKBEN,
    input  logic [6:0] KB_ADDR,
    output logic       KB_PA7,
    output logic       KB_CA2,
    output logic       BREAK
);

    logic [1:0]  clk_sync;
    logic [1:0]  dat_sync;
    logic        clk_prev;
    logic        fall;
    logic        din;

    rx_state_t   state;
    rx_state_t   state_n;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par;
    logic [15:0] idle_cnt;
    logic        timeout;
    logic        frame_ok;
    logic        frame_bad;

    logic        ext;
    logic        brk;
    logic        lk_valid;
    logic [2:0]  lk_row;
    logic [3:0]  lk_col;

    logic [N_ROWS-1:0][N_COLS-1:0] matrix;
    logic [7:0]  links;
    logic [3:0]  col_cnt;
    logic [3:0]  scan_col;
    logic        col_any;

    assign links = DIP_LINKS;

    // Two-flop synchronisers plus delayed clock for edge detection
    always_ff @(posedge clk) begin
        if (RESET) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DATA};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign din     = dat_sync[1];
    assign timeout = (state != RX_IDLE) && !fall
                   && (idle_cnt == TIMEOUT - 16'd1);

    // Frame state register
    always_ff @(posedge clk) begin
        if (RESET) state <= RX_IDLE;
        else       state <= state_n;
    end

    // Frame next state; stop bit judges the whole frame
    always_comb begin
        state_n   = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (timeout) begin
            state_n = RX_IDLE;
        end else if (fall) begin
            case (state)
                RX_IDLE:   if (!din) state_n = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_n = RX_PARITY;
                RX_PARITY: state_n = RX_STOP;
                RX_STOP: begin
                    state_n   = RX_IDLE;
                    frame_ok  = par & din;
                    frame_bad = ~(par & din);
                end
                default:   state_n = RX_IDLE;
            endcase
        end
    end

    // Shift register, bit count, running parity, inactivity timer
    always_ff @(posedge clk) begin
        if (RESET) begin
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            par      <= 1'b0;
            idle_cnt <= 16'd0;
        end else begin
            if (fall || state == RX_IDLE) idle_cnt <= 16'd0;
            else                          idle_cnt <= idle_cnt + 16'd1;
            if (fall) begin
                case (state)
                    RX_IDLE: begin
                        bit_cnt <= 3'd0;
                        par     <= 1'b0;
                    end
                    RX_DATA: begin
                        shreg   <= {din, shreg[7:1]};
                        par     <= par ^ din;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: par <= par ^ din;
                    default: ;
                endcase
            end
        end
    end

    ps2_to_bbc u_map (
        .code  ({ext, shreg}),
        .valid (lk_valid),
        .row   (lk_row),
        .col   (lk_col)
    );

    // Byte decode: prefixes set flags, keys update matrix or BREAK
    always_ff @(posedge clk) begin
        if (RESET) begin
            ext    <= 1'b0;
            brk    <= 1'b0;
            BREAK  <= 1'b0;
            matrix <= '0;
        end else if (frame_bad) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (frame_ok) begin
            if (shreg == PS2_EXT) begin
                ext <= 1'b1;
            end else if (shreg == PS2_BRK) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (shreg == PS2_F12)
                    BREAK <= ~brk;
                else if (lk_valid)
                    matrix[lk_row][lk_col] <= ~brk;
            end
        end
    end

    // Addressed key; row 0 columns 2-9 are the links
    always_comb begin
        KB_PA7 = 1'b0;
        if (KB_ADDR[3:0] < 4'd10) begin
            if (KB_ADDR[6:4] == 3'd0 && KB_ADDR[3:0] >= 4'd2)
                KB_PA7 = links[3'(KB_ADDR[3:0] - 4'd2)];
            else
                KB_PA7 = matrix[KB_ADDR[6:4]][KB_ADDR[3:0]];
        end
    end

    assign scan_col = nKBEN ? col_cnt : KB_ADDR[3:0];

    // Any key in rows 1-7 of the scanned column
    always_comb begin
        col_any = 1'b0;
        if (scan_col < 4'd10)
            for (int r = 1; r < N_ROWS; r++)
                col_any = col_any | matrix[3'(r)][scan_col];
    end

    // Column counter and registered CA2 on the 1 MHz strobe
    always_ff @(posedge clk) begin
        if (RESET) begin
            col_cnt <= 4'd0;
            KB_CA2  <= 1'b0;
        end else if (clk_en) begin
            if (nKBEN) col_cnt <= col_cnt + 4'd1;
            KB_CA2 <= col_any;
        end
    end

endmodule

// File: tb/tb_bbc_keyboard.sv
// Bench for bbc_keyboard: directed cases plus random key traffic.
// Expectations come from a key-state array and BBC scan rules.
module tb_bbc_keyboard;

    localparam logic [7:0]  LINKS = 8'hA5;
    localparam logic [15:0] TMO   = 16'd300;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       clk_en = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       nKBEN = 1'b0;
    logic [6:0] KB_ADDR = 7'h00;
    logic       KB_PA7;
    logic       KB_CA2;
    logic       BREAK;

    int   checks = 0;
    int   failures = 0;
    bit   pressed [128];
    bit   brk_m;
    int   m_cnt;
    logic [7:0] links_v = LINKS;
    logic [8:0] k_code [11];
    logic [6:0] k_addr [11];

    bbc_keyboard #(
        .DIP_LINKS (LINKS),
        .TIMEOUT   (TMO)
    ) dut (
        .clk      (clk),
        .RESET    (RESET),
        .clk_en   (clk_en),
        .PS2_CLK  (PS2_CLK),
        .PS2_DATA (PS2_DATA),
        .nKBEN    (nKBEN),
        .KB_ADDR  (KB_ADDR),
        .KB_PA7   (KB_PA7),
        .KB_CA2   (KB_CA2),
        .BREAK    (BREAK)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit exp_pa7(input logic [6:0] a);
        int col;
        int row;
        col = int'(a[3:0]);
        row = int'(a[6:4]);
        if (col > 9) return 1'b0;
        if (row == 0 && col >= 2) return links_v[col - 2];
        return pressed[a];
    endfunction

    function automatic bit exp_ca2(input int col);
        bit any;
        any = 1'b0;
        if (col > 9) return 1'b0;
        for (int r = 1; r < 8; r++)
            if (pressed[r * 16 + col]) any = 1'b1;
        return any;
    endfunction

    task automatic ps2_bits(input logic [7:0] b, input bit bad, input int n);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            PS2_DATA = fr[i];
            wait_clk(3);
            PS2_CLK = 1'b0;
            wait_clk(5);
            PS2_CLK = 1'b1;
            wait_clk(3);
        end
        PS2_DATA = 1'b1;
        wait_clk(4);
    endtask

    task automatic key_evt(input logic [8:0] code, input logic [6:0] addr,
                           input bit make);
        if (code[8]) ps2_bits(8'hE0, 1'b0, 11);
        if (!make)   ps2_bits(8'hF0, 1'b0, 11);
        ps2_bits(code[7:0], 1'b0, 11);
        if (code == 9'h007) brk_m = make;
        else                pressed[addr] = make;
    endtask

    task automatic check_pa7(input string tag, input logic [6:0] a);
        @(negedge clk);
        KB_ADDR = a;
        #1;
        chk(tag, KB_PA7, exp_pa7(a));
    endtask

    task automatic tick_ce(input bit mode);
        bit e;
        @(negedge clk);
        nKBEN  = mode;
        clk_en = 1'b1;
        e = exp_ca2(mode ? m_cnt : int'(KB_ADDR[3:0]));
        @(negedge clk);
        clk_en = 1'b0;
        chk("ca2", KB_CA2, e);
        if (mode) m_cnt = (m_cnt + 1) % 16;
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1;
        wait_clk(2);
        RESET = 1'b0;
        foreach (pressed[i]) pressed[i] = 1'b0;
        brk_m = 1'b0;
        m_cnt = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        k_code = '{9'h01C, 9'h029, 9'h012, 9'h076, 9'h01A, 9'h015,
                   9'h05A, 9'h175, 9'h014, 9'h066, 9'h007};
        k_addr = '{7'h41, 7'h62, 7'h00, 7'h70, 7'h61, 7'h10,
                   7'h49, 7'h39, 7'h01, 7'h59, 7'h00};
        do_reset();
        wait_clk(2);

        chk("rst_break", BREAK, 1'b0);
        chk("rst_ca2", KB_CA2, 1'b0);
        for (int a = 0; a < 16; a++) check_pa7("rst_row0", 7'(a));
        check_pa7("rst_41", 7'h41);
        check_pa7("rst_7f", 7'h7F);

        key_evt(9'h01C, 7'h41, 1'b1);
        check_pa7("a_make", 7'h41);
        key_evt(9'h01C, 7'h41, 1'b0);
        check_pa7("a_break", 7'h41);

        key_evt(9'h029, 7'h62, 1'b1);
        for (int i = 0; i < 32; i++) tick_ce(1'b1);
        key_evt(9'h029, 7'h62, 1'b0);

        key_evt(9'h012, 7'h00, 1'b1);
        for (int i = 0; i < 16; i++) tick_ce(1'b1);
        check_pa7("shift", 7'h00);
        key_evt(9'h012, 7'h00, 1'b0);

        ps2_bits(8'h1C, 1'b1, 11);
        check_pa7("bad_par", 7'h41);
        ps2_bits(8'hF0, 1'b0, 11);
        ps2_bits(8'h1C, 1'b1, 11);
        key_evt(9'h01C, 7'h41, 1'b1);
        check_pa7("flag_clr", 7'h41);
        key_evt(9'h01C, 7'h41, 1'b0);
        ps2_bits(8'h76, 1'b0, 6);
        wait_clk(int'(TMO) + 20);
        key_evt(9'h076, 7'h70, 1'b1);
        check_pa7("timeout", 7'h70);
        key_evt(9'h076, 7'h70, 1'b0);

        key_evt(9'h007, 7'h00, 1'b1);
        chk("f12_make", BREAK, 1'b1);
        check_pa7("f12_mtx", 7'h00);
        key_evt(9'h01C, 7'h41, 1'b1);
        for (int i = 0; i < 5; i++) tick_ce(1'b1);
        tick_ce(1'b0);
        ps2_bits(8'h29, 1'b0, 4);
        do_reset();
        #1;
        chk("mid_break", BREAK, 1'b0);
        chk("mid_ca2", KB_CA2, 1'b0);
        check_pa7("mid_41", 7'h41);
        key_evt(9'h029, 7'h62, 1'b1);
        for (int i = 0; i < 16; i++) tick_ce(1'b1);
        key_evt(9'h029, 7'h62, 1'b0);

        for (int it = 0; it < 40; it++) begin
            int k;
            bit mk;
            k  = $urandom_range(0, 10);
            mk = 1'($urandom_range(0, 1));
            key_evt(k_code[k], k_addr[k], mk);
            chk("brk_rand", BREAK, brk_m);
            if (k != 10) check_pa7("pa7_key", k_addr[k]);
            check_pa7("pa7_rand", 7'($urandom_range(0, 127)));
            tick_ce(1'($urandom_range(0, 1)));
            tick_ce(1'b1);
        end
        for (int i = 0; i < 16; i++) tick_ce(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
